// File: rtl/bram_pkg.sv
// Shared definitions for the two-port BRAM arbiter: default geometry and port identifiers.
package bram_pkg;

  localparam int unsigned RAM_WIDTH_DEF = 16;
  localparam int unsigned RAM_DEPTH_DEF = 1024;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

  function automatic port_e other_port(input port_e p);
    return (p == PORT_A) ? PORT_B : PORT_A;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter with a combinational grant and a registered priority pointer.
module rr_arbiter2
  import bram_pkg::*;
(
  input  logic clk,
  input  logic rst_ni,
  input  logic req_a_i,
  input  logic req_b_i,
  input  logic accept_i,
  output logic gnt_a_o,
  output logic gnt_b_o
);

  port_e prio_q, prio_d;
  logic  win_a;
  logic  win_b;

  // Grants are forced low while reset is asserted so no command can slip in.
  always_comb begin
    win_a   = req_a_i && (!req_b_i || (prio_q == PORT_A));
    win_b   = req_b_i && !win_a;
    gnt_a_o = rst_ni && win_a;
    gnt_b_o = rst_ni && win_b;
  end

  always_comb begin
    prio_d = prio_q;
    if (accept_i) begin
      prio_d = other_port(win_a ? PORT_A : PORT_B);
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      prio_q <= PORT_A;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/bram_arbiter.sv
// Shares one single-port BRAM between requesters A and B through a registered issue stage
// and routes each read return back to the port that issued it.
module bram_arbiter
  import bram_pkg::*;
#(
  parameter int unsigned RAM_WIDTH  = RAM_WIDTH_DEF,
  parameter int unsigned RAM_DEPTH  = RAM_DEPTH_DEF,
  parameter int unsigned ADDR_WIDTH = $clog2(RAM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_ni,

  input  logic                  a_req_i,
  input  logic                  a_we_i,
  input  logic [ADDR_WIDTH-1:0] a_addr_i,
  input  logic [RAM_WIDTH-1:0]  a_wdata_i,
  output logic                  a_gnt_o,
  output logic                  a_rvalid_o,
  output logic [RAM_WIDTH-1:0]  a_rdata_o,

  input  logic                  b_req_i,
  input  logic                  b_we_i,
  input  logic [ADDR_WIDTH-1:0] b_addr_i,
  input  logic [RAM_WIDTH-1:0]  b_wdata_i,
  output logic                  b_gnt_o,
  output logic                  b_rvalid_o,
  output logic [RAM_WIDTH-1:0]  b_rdata_o,

  output logic                  bram_we_o,
  output logic                  bram_re_o,
  output logic [ADDR_WIDTH-1:0] bram_addr_o,
  output logic [RAM_WIDTH-1:0]  bram_din_o,
  input  logic [RAM_WIDTH-1:0]  bram_dout_i
);

  logic                  gnt_a;
  logic                  gnt_b;
  logic                  accept;

  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [RAM_WIDTH-1:0]  sel_wdata;
  port_e                 sel_owner;

  logic                  we_q, we_d;
  logic                  re_q, re_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [RAM_WIDTH-1:0]  din_q, din_d;
  port_e                 tag_q, tag_d;

  logic                  pend_q, pend_d;
  port_e                 owner_q, owner_d;

  rr_arbiter2 u_arb (
    .clk      (clk),
    .rst_ni   (rst_ni),
    .req_a_i  (a_req_i),
    .req_b_i  (b_req_i),
    .accept_i (accept),
    .gnt_a_o  (gnt_a),
    .gnt_b_o  (gnt_b)
  );

  assign accept = gnt_a || gnt_b;

  always_comb begin
    sel_owner = gnt_b ? PORT_B : PORT_A;
    sel_we    = gnt_b ? b_we_i    : a_we_i;
    sel_addr  = gnt_b ? b_addr_i  : a_addr_i;
    sel_wdata = gnt_b ? b_wdata_i : a_wdata_i;
  end

  // Address, data and tag hold when idle; only the strobes drop back to zero.
  always_comb begin
    we_d    = accept && sel_we;
    re_d    = accept && !sel_we;
    addr_d  = accept ? sel_addr  : addr_q;
    din_d   = accept ? sel_wdata : din_q;
    tag_d   = accept ? sel_owner : tag_q;
    pend_d  = re_q;
    owner_d = tag_q;
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      tag_q   <= PORT_A;
      pend_q  <= 1'b0;
      owner_q <= PORT_A;
    end else begin
      we_q    <= we_d;
      re_q    <= re_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      tag_q   <= tag_d;
      pend_q  <= pend_d;
      owner_q <= owner_d;
    end
  end

  assign a_gnt_o     = gnt_a;
  assign b_gnt_o     = gnt_b;

  assign bram_we_o   = we_q;
  assign bram_re_o   = re_q;
  assign bram_addr_o = addr_q;
  assign bram_din_o  = din_q;

  assign a_rvalid_o  = pend_q && (owner_q == PORT_A);
  assign b_rvalid_o  = pend_q && (owner_q == PORT_B);
  assign a_rdata_o   = a_rvalid_o ? bram_dout_i : '0;
  assign b_rdata_o   = b_rvalid_o ? bram_dout_i : '0;

endmodule

// File: tb/tb_bram_arbiter.sv
// Bench for bram_arbiter: directed scenarios plus random traffic against an accept-order memory model.
module tb_bram_arbiter;

  localparam int W  = 16;
  localparam int D  = 1024;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          a_req = 1'b0, a_we = 1'b0;
  logic [AW-1:0] a_addr = '0;
  logic [W-1:0]  a_wdata = '0;
  logic          b_req = 1'b0, b_we = 1'b0;
  logic [AW-1:0] b_addr = '0;
  logic [W-1:0]  b_wdata = '0;
  logic          a_gnt, b_gnt, a_rvalid, b_rvalid;
  logic [W-1:0]  a_rdata, b_rdata;
  logic          bram_we, bram_re;
  logic [AW-1:0] bram_addr;
  logic [W-1:0]  bram_din;
  logic [W-1:0]  bram_dout = '0;

  always #5 clk = ~clk;

  bram_arbiter #(.RAM_WIDTH(W), .RAM_DEPTH(D)) dut (
    .clk(clk), .rst_ni(rst_n),
    .a_req_i(a_req), .a_we_i(a_we), .a_addr_i(a_addr), .a_wdata_i(a_wdata),
    .a_gnt_o(a_gnt), .a_rvalid_o(a_rvalid), .a_rdata_o(a_rdata),
    .b_req_i(b_req), .b_we_i(b_we), .b_addr_i(b_addr), .b_wdata_i(b_wdata),
    .b_gnt_o(b_gnt), .b_rvalid_o(b_rvalid), .b_rdata_o(b_rdata),
    .bram_we_o(bram_we), .bram_re_o(bram_re), .bram_addr_o(bram_addr),
    .bram_din_o(bram_din), .bram_dout_i(bram_dout)
  );

  // The BRAM itself: one-cycle registered read.
  logic [W-1:0] mem [D] = '{default: '0};
  always @(posedge clk) begin
    if (bram_we) mem[bram_addr] <= bram_din;
    if (bram_re) bram_dout <= mem[bram_addr];
  end

  // Reference model: memory updated in accept order, returns scheduled two cycles after accept.
  typedef struct {
    int unsigned  due;
    bit           port;
    logic [W-1:0] data;
  } ret_t;

  logic [W-1:0]  ref_mem [D] = '{default: '0};
  ret_t          rq[$];
  bit            m_prio_b = 1'b0;
  logic          exp_we = 1'b0, exp_re = 1'b0;
  logic [AW-1:0] exp_addr = '0;
  logic [W-1:0]  exp_din = '0;
  int unsigned   cyc = 0;

  int n_chk  = 0;
  int n_pass = 0;

  logic          obs_ga, obs_gb, obs_rva, obs_rvb;
  logic [W-1:0]  obs_rda;
  logic [AW-1:0] obs_addr;
  logic [W-1:0]  last_a_rd = '0, last_b_rd = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    bit           ga, gb, ev_a, ev_b, we;
    logic [W-1:0] ed;
    logic [AW-1:0] ad;
    logic [W-1:0] wd;
    ret_t         r;
    @(negedge clk);
    ga = 0; gb = 0; ev_a = 0; ev_b = 0; ed = '0;
    if (!rst_n) begin
      rq.delete();
      m_prio_b = 1'b0;
      exp_we = 1'b0; exp_re = 1'b0; exp_addr = '0; exp_din = '0;
    end else begin
      if (a_req && b_req) begin
        ga = !m_prio_b; gb = m_prio_b;
      end else begin
        ga = a_req; gb = b_req;
      end
      if (rq.size() > 0 && rq[0].due == cyc) begin
        ev_a = !rq[0].port; ev_b = rq[0].port; ed = rq[0].data;
      end
    end
    chk("gnt_a", a_gnt, ga);
    chk("gnt_b", b_gnt, gb);
    chk("rvalid_a", a_rvalid, ev_a);
    chk("rvalid_b", b_rvalid, ev_b);
    chk("rdata_a", a_rdata, ev_a ? ed : '0);
    chk("rdata_b", b_rdata, ev_b ? ed : '0);
    chk("bram_we", bram_we, exp_we);
    chk("bram_re", bram_re, exp_re);
    chk("bram_addr", bram_addr, exp_addr);
    chk("bram_din", bram_din, exp_din);
    obs_ga = a_gnt; obs_gb = b_gnt; obs_rva = a_rvalid; obs_rvb = b_rvalid;
    obs_rda = a_rdata; obs_addr = bram_addr;
    if (a_rvalid) last_a_rd = a_rdata;
    if (b_rvalid) last_b_rd = b_rdata;
    if (ev_a || ev_b) void'(rq.pop_front());
    if (ga || gb) begin
      we = ga ? a_we : b_we;
      ad = ga ? a_addr : b_addr;
      wd = ga ? a_wdata : b_wdata;
      m_prio_b = ga;
      exp_we = we; exp_re = !we; exp_addr = ad; exp_din = wd;
      if (we) begin
        ref_mem[ad] = wd;
      end else begin
        r.due = cyc + 2; r.port = gb; r.data = ref_mem[ad];
        rq.push_back(r);
      end
    end else begin
      exp_we = 1'b0; exp_re = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (ga) a_req = 1'b0;
    if (gb) b_req = 1'b0;
  endtask

  task automatic set_a(input bit we, input int addr, input logic [W-1:0] d);
    a_req = 1'b1; a_we = we; a_addr = AW'(addr); a_wdata = d;
  endtask

  task automatic set_b(input bit we, input int addr, input logic [W-1:0] d);
    b_req = 1'b1; b_we = we; b_addr = AW'(addr); b_wdata = d;
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 32 && (a_req || b_req); k++) tick();
    chk(tag, {a_req, b_req}, 2'b00);
    for (int k = 0; k < 3; k++) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  function automatic int pick_addr();
    return ($urandom_range(0, 7) == 0) ? D - 1 : int'($urandom_range(0, 7));
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int an, bn;
    // Reset state and single-port write/read
    do_reset();
    set_a(1, 0, 16'hABCD);
    tick(); chk("t1_wr_gnt", obs_ga, 1'b1);
    set_a(0, 0, '0);
    tick(); chk("t1_rd_gnt", obs_ga, 1'b1);
    tick(); chk("t1_rv_early", obs_rva, 1'b0);
    tick(); chk("t1_rv", obs_rva, 1'b1);
    chk("t1_rdata", obs_rda, 16'hABCD);
    chk("t1_rvb", obs_rvb, 1'b0);

    // Continuous contention from reset
    do_reset();
    an = 0; bn = 0;
    set_a(1, 100, 16'($urandom));
    set_b(1, 200, 16'($urandom));
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("cont_gnt_a", obs_ga, (i % 2 == 0));
      chk("cont_gnt_b", obs_gb, (i % 2 == 1));
      if (i > 0) chk("cont_addr", obs_addr, ((i - 1) % 2 == 0) ? 100 + (i - 1) / 2 : 200 + (i - 1) / 2);
      if (!a_req) begin an++; set_a(1, 100 + an, 16'($urandom)); end
      if (!b_req) begin bn++; set_b(1, 200 + bn, 16'($urandom)); end
    end
    a_req = 1'b0; b_req = 1'b0;
    tick(); chk("cont_addr_last", obs_addr, 203);

    // Cross-port ordering: A's write precedes B's read of the same address
    set_a(1, 5, 16'h1234);
    set_b(0, 5, '0);
    tick();
    chk("xp_gnt_a", obs_ga, 1'b1);
    chk("xp_gnt_b", obs_gb, 1'b0);
    drain("xp_drain");
    chk("xp_rdata", last_b_rd, 16'h1234);

    // Pointer hold: B alone three times, then both
    for (int i = 0; i < 3; i++) begin
      set_b(0, i, '0);
      tick(); chk("ph_gnt_b", obs_gb, 1'b1);
    end
    set_a(0, 1, '0);
    set_b(0, 2, '0);
    tick();
    chk("ph_gnt_a", obs_ga, 1'b1);
    chk("ph_gnt_b_lose", obs_gb, 1'b0);
    drain("ph_drain");

    // Boundary address
    set_a(1, D - 1, 16'hFFFF); tick();
    set_a(0, D - 1, '0); tick();
    drain("bnd_drain_hi");
    chk("bnd_hi", last_a_rd, 16'hFFFF);
    set_a(0, 0, '0); tick();
    drain("bnd_drain_lo");
    chk("bnd_lo", last_a_rd, 16'hABCD);

    // Reset one cycle after a read accept
    set_a(0, D - 1, '0);
    tick(); chk("rm_acc", obs_ga, 1'b1);
    rst_n = 1'b0;
    set_a(0, 7, '0);
    tick(); chk("rm_rv0", obs_rva, 1'b0); chk("rm_ga0", obs_ga, 1'b0);
    tick(); chk("rm_rv1", obs_rva, 1'b0);
    tick(); chk("rm_rv2", obs_rva, 1'b0);
    rst_n = 1'b1;
    set_b(0, 8, '0);
    tick();
    chk("rm_prio_a", obs_ga, 1'b1);
    chk("rm_prio_b", obs_gb, 1'b0);
    drain("rm_drain");

    // Random traffic with occasional withdrawals
    for (int i = 0; i < 400; i++) begin
      if (!a_req && $urandom_range(0, 2) == 0) set_a(1'($urandom_range(0, 1)), pick_addr(), 16'($urandom));
      else if (a_req && $urandom_range(0, 15) == 0) a_req = 1'b0;
      if (!b_req && $urandom_range(0, 2) == 0) set_b(1'($urandom_range(0, 1)), pick_addr(), 16'($urandom));
      else if (b_req && $urandom_range(0, 15) == 0) b_req = 1'b0;
      tick();
    end
    drain("rnd_drain");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
